// File: rtl/p2s_rr_sched.sv
// p2s_rr_sched: round-robin arbiter feeding a parallel-to-serial shifter.
// Requesters present a word and hold req_i until granted. The winner's word
// is serialized LSB first, one bit per cycle. A new frame can be granted on
// the last bit of the current one, so back-to-back frames have no gap.
//
// Handshake: req_i[k] is a level request. It is accepted in the cycle where
// gnt_o[k]=1, and data_i[k] is captured on the clock edge that ends that
// cycle. There is no ready signal: a grant is only issued in IDLE or on the
// final bit of a frame. A request dropped before its grant is forgotten.
// Downstream, valid_o (mirrored on busy_o) marks every cycle that carries a
// data bit. last_o marks the final bit of a frame.
module p2s_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      serial_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic [SRC_W-1:0]          src_o,
  output logic                      busy_o,
  output logic                      dbg_state_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                last_bit;
  logic                arb_en;
  logic                win_found;
  logic [SRC_W-1:0]    win_idx;
  logic [SRC_W-1:0]    cand;
  logic                grant;

  // Final bit of the current frame; this is the only SHIFT cycle that may grant.
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == CNT_W'(DATA_W - 1));

  // Arbitration is allowed in IDLE or on the last bit, and never under reset.
  assign arb_en = !reset && ((state_q == IDLE) || last_bit);

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  // NUM_REQ is a power of two, so the SRC_W-bit add wraps modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_q + SRC_W'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = arb_en && win_found;

  // One-hot grant pulse, combinational in the arbitration cycle.
  always_comb begin
    gnt_o = '0;
    if (grant) begin
      gnt_o = NUM_REQ'(1) << win_idx;
    end
  end

  // Next-state logic. A grant always loads a fresh frame. Otherwise SHIFT
  // advances one bit, and the last bit without a grant returns to IDLE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    src_d     = src_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
      end
      SHIFT: begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
    if (grant) begin
      state_d   = SHIFT;
      shift_d   = data_i[win_idx * DATA_W +: DATA_W];
      bit_cnt_d = '0;
      src_d     = win_idx;
      rr_ptr_d  = win_idx + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      src_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      src_q     <= src_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Serial-side outputs. They are forced quiet outside a frame, and src_o
  // holds the owner of the most recent frame.
  always_comb begin
    valid_o     = (state_q == SHIFT);
    busy_o      = valid_o;
    serial_o    = valid_o & shift_q[0];
    last_o      = last_bit;
    src_o       = src_q;
    dbg_state_o = state_q;
  end

endmodule

// File: doc/p2s_rr_sched.md
P2S_RR_SCHED -- requirements
Module: p2s_rr_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; SHALL be a power of 2, 2..8.
REQ-002 Parameter DATA_W, default 4: word width; SHALL be 2..16.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req_i, input, NUM_REQ: per-requester request; level, held until granted.
REQ-006 Port data_i, input, NUM_REQ*DATA_W: requester k's word at bits [k*DATA_W +: DATA_W]; must be stable while req_i[k]=1.
REQ-007 Port gnt_o, output, NUM_REQ: one-hot, one-cycle grant pulse; the winner's word is captured on that edge.
REQ-008 Port serial_o, output, 1: serialized bit, LSB first.
REQ-009 Port valid_o, output, 1: serial_o carries a data bit.
REQ-010 Port last_o, output, 1: current bit is bit DATA_W-1 of the frame.
REQ-011 Port src_o, output, log2(NUM_REQ): index of the requester owning the current frame.
REQ-012 Port busy_o, output, 1: equals valid_o; provided for upstream flow control.

Function
REQ-013 FSM states: IDLE, SHIFT.
REQ-014 IDLE with req_i==0: stay in IDLE; gnt_o=0; valid_o=0.
REQ-015 IDLE with req_i!=0: gnt_o is combinational that cycle, one-hot on the winner.
- On the clock edge ending that cycle: shift_reg <= winner's word, src_o <= winner, bit_cnt <= 0, state <= SHIFT.
REQ-016 Winner selection: first set req_i bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-017 rr_ptr SHALL update to (winner+1) mod NUM_REQ on every grant, and only on a grant.
REQ-018 SHIFT: valid_o=1, serial_o=shift_reg[0].
- Each edge: shift_reg >>= 1 (zero fill), bit_cnt += 1.
- The frame lasts exactly DATA_W cycles.
REQ-019 last_o=1 when state==SHIFT and bit_cnt==DATA_W-1; otherwise 0.
REQ-020 Final SHIFT cycle (last_o=1) with req_i!=0: arbitrate and grant exactly as in REQ-015, in the same cycle.
- Next frame starts the following cycle with no gap; valid_o stays 1.
REQ-021 Final SHIFT cycle with req_i==0: state <= IDLE; valid_o=0 the next cycle.
REQ-022 gnt_o SHALL be 0 in every SHIFT cycle other than the final one; requests arriving mid-frame wait.
REQ-023 A request deasserted before its grant is dropped silently; no state is retained for it.
REQ-024 A requester re-asserting req_i immediately after its own grant SHALL lose to any other pending requester (REQ-016/017).
REQ-025 serial_o=0, last_o=0 and src_o holds its last value whenever valid_o=0.
REQ-026 bit_cnt width: log2(DATA_W)+1 bits; no wrap beyond DATA_W-1.

Reset
REQ-027 On reset=1 at a clock edge: state=IDLE, shift_reg=0, bit_cnt=0, rr_ptr=0, src_o=0.
REQ-028 On reset=1: gnt_o=0, valid_o=0, serial_o=0, last_o=0, busy_o=0 from the next cycle.
REQ-029 gnt_o SHALL be forced to 0 while reset=1.
REQ-030 Reset mid-frame aborts the frame: no further bits, and no grant for the aborted or pending requesters until they are re-arbitrated after reset.

Verification
REQ-031 Single request, defaults, req_i=0001, word0=4'b1011:
- gnt_o=0001 for one cycle.
- serial_o 1,1,0,1 on the next 4 cycles with valid_o=1; last_o on the 4th; src_o=0.
- Then IDLE.
REQ-032 req_i=1111 held (re-asserted after each grant), words 1,2,4,8:
- Grants in order 0,1,2,3,0.
- Frames back-to-back; valid_o continuously 1 for 16+ cycles.
REQ-033 rr_ptr=2 after granting 1, req_i=0011:
- Requester 0 is granted (wrap), then 1; requester 1 is never granted twice consecutively while 0 is pending.
REQ-034 Request arriving mid-frame:
- req_i[3] asserted on bit 1 of a frame: gnt_o=1000 only on that frame's last_o cycle.
- Its frame starts the next cycle.
REQ-035 Reset mid-frame:
- reset=1 on bit 2 of a frame with req_i=0110 pending: next cycle all outputs 0, state IDLE.
- After release, requester 1 is granted first (rr_ptr=0).
REQ-036 Withdrawn request:
- req_i[2] pulsed for 2 cycles during a frame, then dropped before that frame's last cycle: no grant is issued; the block returns to IDLE.
